regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, the successor to the single-write, two-read register file. It provides NRD combinational read ports with same-cycle write-to-read bypass and NWR posedge write ports. A per-register busy scoreboard lets issue logic detect RAW hazards. After reset, a sequential init walk zeroes the storage one entry per cycle, so the array maps onto RAM-style storage. It sits between decode/issue (read and issue ports) and writeback (write ports).

## Interface

- XLEN, 32: data width.
- NREG, 32: number of architectural registers; power of two, ≥4. Entry 0 is hardwired zero.
- NRD, 2: number of read ports, 1..4.
- NWR, 2: number of write ports, 1..2.
- BYPASS, 1: 1 enables same-cycle write-to-read forwarding; 0 returns stored data only.
- AW, $clog2(NREG): address width (derived).

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  scoreboard busy bit for each read address.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_rd  in  AW  destination register of the issuing instruction.
- ready  out  1  high once the init walk is complete; low during reset and init.

## Operation

- States are INIT and RUN; state is registered.
- **Reset (rst=1 at a posedge):**
  - state ← INIT, init_cnt ← 1, every busy bit ← 0.
  - Reset applied mid-operation aborts everything in flight and restarts INIT.
- **INIT:**
  - Each posedge writes mem[init_cnt] ← 0 and increments init_cnt.
  - The edge that writes entry NREG-1 moves state to RUN.
  - wr_en and iss_valid are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- **RUN, write:**
  - On posedge, mem[wr_addr[j]] ← wr_data[j] for each j with wr_en[j]=1 and wr_addr[j] ≠ 0.
  - If both ports target the same address, the higher-index port wins.
  - Writes to entry 0 are discarded.
- **RUN, read:**
  - rd_addr = 0 gives data 0 and busy 0.
  - Otherwise, if BYPASS=1 and any enabled write port matches rd_addr this cycle, return that port's wr_data; the highest-index match wins.
  - Otherwise return mem[rd_addr].
- **RUN, scoreboard:**
  - An enabled write (addr ≠ 0) clears busy[addr].
  - iss_valid with iss_rd ≠ 0 sets busy[iss_rd].
  - If a set and a clear hit the same register in the same cycle, the set wins (the issuing instruction is younger).
  - busy[0] is always 0.
  - rd_busy[i] = busy[rd_addr[i]] AND NOT (an enabled write to rd_addr[i] this cycle). The clear is visible combinationally, matching the bypass.
- Outputs after reset: ready = 0, rd_busy = 0, rd_data = 0.

## Timing

- Read latency is 0 cycles (combinational from rd_addr, wr_*, and state).
- Write latency: the value is stored at the posedge and visible from stored data in the next cycle. With BYPASS=1 it is also visible in the same cycle.
- busy set: visible on rd_busy in the cycle after iss_valid.
- busy clear: visible in the same cycle as the write.
- Init: ready rises after exactly NREG-1 posedges with rst=0, counted from the first posedge after rst falls (31 edges with default parameters).
- There is no backpressure. Issue logic must hold off until ready=1; inputs presented earlier are dropped.

## Test plan

- Reset-then-init: hold rst for 2 cycles, then release. ready must stay 0 for 31 edges and be 1 after edge 31. Every address must then read 0 with busy 0.
- Write/read with bypass: write x5 = 0xDEADBEEF on port 0 and read x5 in the same cycle. BYPASS=1 must return 0xDEADBEEF; BYPASS=0 must return 0 in that cycle and 0xDEADBEEF in the next.
- Dual-write conflict: port 0 writes x7 = 0x11 and port 1 writes x7 = 0x22 in the same cycle. The same-cycle read and all later reads of x7 must return 0x22.
- x0 protection: write x0 = 0xFFFFFFFF and issue with iss_rd = 0. x0 must read 0 and busy must stay 0.
- Scoreboard: issue x3, then x3 must read busy 1 on the next cycle. Three cycles later, a write to x3 must make busy 0 in that same cycle. A cycle with iss_rd = 3 and a write to x3 together must leave busy = 1 afterwards.
- Mid-operation reset: fill x1..x4 with nonzero data and set busy on x2, then assert rst for 1 cycle. ready must drop, and all reads must return 0 with busy 0. After 31 edges ready = 1 and x1..x4 read 0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a busy scoreboard.
// NRD combinational read ports with optional same-cycle write forwarding,
// NWR posedge write ports, and a sequential zeroing walk after reset so the
// storage array needs no reset of its own and can map onto RAM.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                ready
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ENTRY = AW'(NREG - 1);

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     init_cnt;
  logic [XLEN-1:0]   mem [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;

  // State register; reset always restarts the zeroing walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Leave INIT on the same edge that zeroes the last entry.
  always_comb begin
    state_next = state;
    if (state == S_INIT && init_cnt == LAST_ENTRY) begin
      state_next = S_RUN;
    end
  end

  // Walk pointer; entry 0 is never stored, so the walk starts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= AW'(1);
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + AW'(1);
    end
  end

  // Storage writes: zeroing during INIT, port writes in RUN with the
  // higher-index port applied last so it wins an address conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        mem[init_cnt] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
            mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Scoreboard next value: writebacks clear, then the issuing (younger)
  // instruction sets, so a same-register set beats the clear.
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        busy_next[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (iss_valid) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register; only RUN-state issue/writeback traffic counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (state == S_RUN) begin
      busy <= busy_next;
    end
  end

  // Read ports: x0 and the INIT phase read as zero/not-busy; a matching
  // write in flight hides the busy bit and optionally forwards its data.
  always_comb begin
    logic [AW-1:0] ra;
    logic          hit;
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    hit     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra  = rd_addr[i*AW +: AW];
      hit = 1'b0;
      if (state == S_RUN && ra != '0) begin
        rd_data[i*XLEN +: XLEN] = mem[ra];
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
            hit = 1'b1;
            if (BYPASS != 0) begin
              rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
            end
          end
        end
        rd_busy[i] = busy[ra] & ~hit;
      end
    end
  end

  assign ready = (state == S_RUN);

endmodule
